// File: rtl/rv64g_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv64g_pkg
// Description : Shared constants and types for the rv64g register-lock
//               scoreboard: register count, writeback port count and the
//               scoreboard state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rv64g_pkg;

    localparam int NUM_REGS     = 32;
    localparam int NUM_WB_PORTS = 2;

    // Scoreboard control state; JUMP and DRAIN lock the whole register file
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        JUMP  = 2'd2,
        DRAIN = 2'd3
    } sb_state_e;

endpackage : rv64g_pkg
`default_nettype wire

// File: rtl/rv64g_reg_lock_scoreboard_sb_counter.sv
`default_nettype none
// ============================================================================
// Module      : sb_counter
// Description : Outstanding-write counter for one register. Counts up by one
//               per issue and down by up to DW-bit "dec" writebacks per cycle.
//               Clamps at max (overflow flag) and at zero (underflow flag).
// Revision    : 1.0 - initial release
// ============================================================================
module sb_counter #(
    parameter int CW = 2,
    parameter int DW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic [DW-1:0] i_dec,
    output logic [CW-1:0] o_count,
    output logic [CW-1:0] o_count_nxt,
    output logic          o_ovf,
    output logic          o_unf
);

    // Wide enough to hold count+1 and the largest decrement without wrapping
    localparam int            WW    = (CW + 1 > DW) ? CW + 1 : DW;
    localparam logic [WW-1:0] c_MAX = WW'((1 << CW) - 1);

    logic [CW-1:0] r_count;
    logic [WW-1:0] w_up;
    logic [WW-1:0] w_dec_ext;
    logic [WW-1:0] w_net;

    // Net update for the cycle with clamping at both ends
    always_comb begin
        w_up        = WW'(r_count) + WW'(i_inc);
        w_dec_ext   = WW'(i_dec);
        w_net       = w_up - w_dec_ext;
        o_count_nxt = r_count;
        o_ovf       = 1'b0;
        o_unf       = 1'b0;
        if (w_up < w_dec_ext) begin
            o_unf       = 1'b1;
            o_count_nxt = '0;
        end else if (w_net > c_MAX) begin
            o_ovf       = 1'b1;
            o_count_nxt = c_MAX[CW-1:0];
        end else begin
            o_count_nxt = w_net[CW-1:0];
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= o_count_nxt;
        end
    end

    assign o_count = r_count;

endmodule : sb_counter
`default_nettype wire

// File: rtl/rv64g_reg_lock_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rv64g_reg_lock_scoreboard
// Description : Tracks outstanding register writes between launch and
//               writeback and produces the per-register lock vector for the
//               instruction launcher. Jumps in flight and pipeline clears lock
//               the whole register file until the datapath is quiet.
// Revision    : 1.0 - initial release
// ============================================================================
module rv64g_reg_lock_scoreboard
    import rv64g_pkg::*;
#(
    parameter int NR  = NUM_REGS,
    parameter int NWB = NUM_WB_PORTS,
    parameter int CW  = 2
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic                     clear_i,
    input  logic                     issue_valid_i,
    input  logic                     issue_ready_i,
    input  logic [$clog2(NR)-1:0]    issue_rd_i,
    input  logic                     issue_jump_i,
    input  logic [NWB-1:0]           wb_valid_i,
    input  logic [NWB*$clog2(NR)-1:0] wb_rd_i,
    input  logic                     jump_done_i,
    output logic [NR-1:0]            locks_o,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int RW = $clog2(NR);
    localparam int DW = $clog2(NWB + 1);

    sb_state_e     r_state;
    logic          r_err;

    logic          w_fire;
    logic          w_accept;
    logic          w_global;
    logic          w_any_busy;
    logic          w_any_nxt;
    logic          w_err;
    logic [NR-1:0] w_busy;
    logic [NR-1:0] w_busy_nxt;
    logic [NR-1:0] w_ovf;
    logic [NR-1:0] w_unf;

    // Issues arriving while draining are dropped: the launcher should be
    // fully locked then, so such an issue is a protocol error, not work.
    assign w_fire   = issue_valid_i & issue_ready_i;
    assign w_accept = w_fire & (r_state != DRAIN);

    // x0 has no counter and is never busy
    assign w_busy[0]     = 1'b0;
    assign w_busy_nxt[0] = 1'b0;
    assign w_ovf[0]      = 1'b0;
    assign w_unf[0]      = 1'b0;

    generate
        for (genvar r = 1; r < NR; r++) begin : g_cnt
            logic          w_inc;
            logic [DW-1:0] w_dec;
            logic [CW-1:0] w_count;
            logic [CW-1:0] w_count_nxt;

            assign w_inc = w_accept && (issue_rd_i == RW'(r));

            // Number of writeback ports retiring this register this cycle
            always_comb begin
                w_dec = '0;
                for (int p = 0; p < NWB; p++) begin
                    if (wb_valid_i[p] && (wb_rd_i[p*RW +: RW] == RW'(r))) begin
                        w_dec = w_dec + DW'(1);
                    end
                end
            end

            sb_counter #(
                .CW (CW),
                .DW (DW)
            ) u_cnt (
                .clk         (clk_i),
                .rst         (srst_i),
                .i_inc       (w_inc),
                .i_dec       (w_dec),
                .o_count     (w_count),
                .o_count_nxt (w_count_nxt),
                .o_ovf       (w_ovf[r]),
                .o_unf       (w_unf[r])
            );

            assign w_busy[r]     = (w_count != '0);
            assign w_busy_nxt[r] = (w_count_nxt != '0);
        end
    endgenerate

    assign w_any_busy = |w_busy;
    assign w_any_nxt  = |w_busy_nxt;

    // Protocol violations detected this cycle, reported one cycle later
    assign w_err = (|w_ovf) | (|w_unf)
                 | (w_fire && (r_state == DRAIN))
                 | (jump_done_i && (r_state != JUMP))
                 | (w_fire && issue_jump_i && (r_state == JUMP));

    // Control FSM and error pulse register; branches are in priority order
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_err;
            if (clear_i) begin
                r_state <= DRAIN;
            end else if (r_state == DRAIN) begin
                if (!w_any_busy && !(|wb_valid_i)) begin
                    r_state <= IDLE;
                end
            end else if (w_fire && issue_jump_i) begin
                r_state <= JUMP;
            end else if (r_state == JUMP) begin
                if (jump_done_i) begin
                    r_state <= w_any_nxt ? RUN : IDLE;
                end
            end else begin
                r_state <= w_any_nxt ? RUN : IDLE;
            end
        end
    end

    // Outputs decode registered state only, so inputs never reach locks_o
    assign w_global = (r_state == JUMP) || (r_state == DRAIN);
    assign locks_o  = {w_busy[NR-1:1] | {(NR-1){w_global}}, 1'b0};
    assign busy_o   = w_any_busy | (r_state != IDLE);
    assign err_o    = r_err;

endmodule : rv64g_reg_lock_scoreboard
`default_nettype wire

// File: tb/tb_rv64g_reg_lock_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv64g_reg_lock_scoreboard
// Description : Self-checking bench for rv64g_reg_lock_scoreboard. A table of
//               one-cycle input vectors with hand-derived expected outputs is
//               replayed through a scoreboard queue, followed by a few
//               hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv64g_reg_lock_scoreboard;

    localparam logic [31:0] c_ALL = 32'hFFFF_FFFE;

    logic        clk_i = 1'b0;
    logic        srst_i;
    logic        clear_i;
    logic        issue_valid_i;
    logic        issue_ready_i;
    logic [4:0]  issue_rd_i;
    logic        issue_jump_i;
    logic [1:0]  wb_valid_i;
    logic [9:0]  wb_rd_i;
    logic        jump_done_i;
    logic [31:0] locks_o;
    logic        busy_o;
    logic        err_o;

    rv64g_reg_lock_scoreboard dut (
        .clk_i         (clk_i),
        .srst_i        (srst_i),
        .clear_i       (clear_i),
        .issue_valid_i (issue_valid_i),
        .issue_ready_i (issue_ready_i),
        .issue_rd_i    (issue_rd_i),
        .issue_jump_i  (issue_jump_i),
        .wb_valid_i    (wb_valid_i),
        .wb_rd_i       (wb_rd_i),
        .jump_done_i   (jump_done_i),
        .locks_o       (locks_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        srst;
        logic        clr;
        logic        iv;
        logic        ir;
        logic [4:0]  ird;
        logic        ij;
        logic [1:0]  wbv;
        logic [4:0]  wb0;
        logic [4:0]  wb1;
        logic        jd;
        logic [31:0] locks;
        logic        busy;
        logic        err;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] locks;
        logic        busy;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic add(input logic srst, input logic clr, input logic iv, input logic ir,
                       input int ird, input logic ij, input logic [1:0] wbv,
                       input int wb0, input int wb1, input logic jd,
                       input logic [31:0] locks, input logic busy, input logic err);
        vec_t v;
        v.srst = srst; v.clr = clr; v.iv = iv; v.ir = ir; v.ird = 5'(ird); v.ij = ij;
        v.wbv = wbv; v.wb0 = 5'(wb0); v.wb1 = 5'(wb1); v.jd = jd;
        v.locks = locks; v.busy = busy; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic srst, input logic clr, input logic iv, input logic ir,
                         input logic [4:0] ird, input logic ij, input logic [1:0] wbv,
                         input logic [4:0] wb0, input logic [4:0] wb1, input logic jd);
        srst_i = srst; clear_i = clr; issue_valid_i = iv; issue_ready_i = ir;
        issue_rd_i = ird; issue_jump_i = ij; wb_valid_i = wbv;
        wb_rd_i = {wb1, wb0}; jump_done_i = jd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        exp_t e;
        int   k;
        int   waited;

        idle();
        srst_i = 1'b1;

        //   srst clr iv ir rd  ij wbv   wb0 wb1 jd  locks          busy err
        add(1, 0, 0, 0,  0, 0, 2'b00,  0,  0, 0, 32'h0,         0, 0); // reset
        add(0, 0, 1, 1,  5, 0, 2'b00,  0,  0, 0, 32'h0000_0020, 1, 0); // issue x5
        add(0, 0, 0, 0,  0, 0, 2'b00,  0,  0, 0, 32'h0000_0020, 1, 0);
        add(0, 0, 0, 0,  0, 0, 2'b01,  5,  0, 0, 32'h0,         0, 0); // wb x5
        add(0, 0, 1, 1,  7, 0, 2'b00,  0,  0, 0, 32'h0000_0080, 1, 0); // x7 cnt 1
        add(0, 0, 1, 1,  7, 0, 2'b00,  0,  0, 0, 32'h0000_0080, 1, 0); // x7 cnt 2
        add(0, 0, 0, 0,  0, 0, 2'b11,  7,  7, 0, 32'h0,         0, 0); // dual wb x7
        add(0, 0, 1, 0,  4, 0, 2'b00,  0,  0, 0, 32'h0,         0, 0); // valid w/o ready
        add(0, 0, 1, 1,  0, 1, 2'b00,  0,  0, 0, c_ALL,         1, 0); // jump rd0
        add(0, 0, 0, 0,  0, 0, 2'b00,  0,  0, 0, c_ALL,         1, 0);
        add(0, 0, 0, 0,  0, 0, 2'b00,  0,  0, 0, c_ALL,         1, 0);
        add(0, 0, 0, 0,  0, 0, 2'b00,  0,  0, 1, 32'h0,         0, 0); // jump done
        add(0, 0, 1, 1,  2, 0, 2'b00,  0,  0, 0, 32'h0000_0004, 1, 0); // x2
        add(0, 0, 1, 1,  6, 1, 2'b00,  0,  0, 0, c_ALL,         1, 0); // jump writing x6
        add(0, 0, 0, 0,  0, 0, 2'b01,  2,  0, 0, c_ALL,         1, 0); // wb x2 in JUMP
        add(0, 0, 0, 0,  0, 0, 2'b00,  0,  0, 1, 32'h0000_0040, 1, 0); // done -> RUN
        add(0, 0, 0, 0,  0, 0, 2'b10,  0,  6, 0, 32'h0,         0, 0); // wb x6 port1
        add(0, 0, 1, 1,  3, 0, 2'b00,  0,  0, 0, 32'h0000_0008, 1, 0); // x3
        add(0, 1, 0, 0,  0, 0, 2'b00,  0,  0, 0, c_ALL,         1, 0); // clear
        add(0, 0, 0, 0,  0, 0, 2'b00,  0,  0, 0, c_ALL,         1, 0);
        add(0, 0, 0, 0,  0, 0, 2'b01,  3,  0, 0, c_ALL,         1, 0); // wb x3
        add(0, 0, 0, 0,  0, 0, 2'b00,  0,  0, 0, 32'h0,         0, 0); // drained
        add(0, 0, 0, 0,  0, 0, 2'b01,  9,  0, 0, 32'h0,         0, 1); // underflow x9
        add(0, 0, 0, 0,  0, 0, 2'b00,  0,  0, 0, 32'h0,         0, 0);
        add(0, 1, 0, 0,  0, 0, 2'b00,  0,  0, 0, c_ALL,         1, 0); // clear, empty
        add(0, 0, 1, 1, 10, 0, 2'b00,  0,  0, 0, 32'h0,         0, 1); // issue in DRAIN
        add(0, 0, 0, 0,  0, 0, 2'b00,  0,  0, 0, 32'h0,         0, 0);
        add(0, 0, 0, 0,  0, 0, 2'b00,  0,  0, 1, 32'h0,         0, 1); // stray jump done
        add(0, 0, 1, 1, 11, 0, 2'b00,  0,  0, 0, 32'h0000_0800, 1, 0); // x11 cnt 1
        add(0, 0, 1, 1, 11, 0, 2'b00,  0,  0, 0, 32'h0000_0800, 1, 0); // cnt 2
        add(0, 0, 1, 1, 11, 0, 2'b00,  0,  0, 0, 32'h0000_0800, 1, 0); // cnt 3
        add(0, 0, 1, 1, 11, 0, 2'b00,  0,  0, 0, 32'h0000_0800, 1, 1); // saturated
        add(0, 0, 0, 0,  0, 0, 2'b11, 11, 11, 0, 32'h0000_0800, 1, 0); // cnt 1
        add(0, 0, 0, 0,  0, 0, 2'b01, 11,  0, 0, 32'h0,         0, 0); // cnt 0
        add(0, 0, 1, 1, 12, 0, 2'b00,  0,  0, 0, 32'h0000_1000, 1, 0); // x12 cnt 1
        add(0, 0, 1, 1, 12, 0, 2'b01, 12,  0, 0, 32'h0000_1000, 1, 0); // issue+wb hold
        add(0, 0, 0, 0,  0, 0, 2'b10,  0, 12, 0, 32'h0,         0, 0);
        add(0, 0, 1, 1, 13, 0, 2'b01, 13,  0, 0, 32'h0,         0, 0); // issue+wb at 0
        add(0, 0, 1, 1,  0, 1, 2'b00,  0,  0, 0, c_ALL,         1, 0); // jump
        add(0, 0, 1, 1,  0, 1, 2'b00,  0,  0, 0, c_ALL,         1, 1); // second jump
        add(0, 0, 0, 0,  0, 0, 2'b00,  0,  0, 1, 32'h0,         0, 0);
        add(0, 0, 1, 1,  0, 0, 2'b00,  0,  0, 0, 32'h0,         0, 0); // issue x0
        add(0, 0, 1, 1, 14, 0, 2'b00,  0,  0, 0, 32'h0000_4000, 1, 0);
        add(0, 0, 1, 1, 15, 0, 2'b00,  0,  0, 0, 32'h0000_C000, 1, 0);
        add(1, 0, 0, 0,  0, 0, 2'b01,  9,  0, 0, 32'h0,         0, 0); // reset mid-RUN
        add(0, 0, 0, 0,  0, 0, 2'b00,  0,  0, 0, 32'h0,         0, 0);
        add(0, 0, 1, 1,  0, 1, 2'b00,  0,  0, 0, c_ALL,         1, 0); // jump
        add(0, 1, 0, 0,  0, 0, 2'b00,  0,  0, 0, c_ALL,         1, 0); // clear drops jump
        add(0, 0, 0, 0,  0, 0, 2'b00,  0,  0, 1, 32'h0,         0, 1); // done in DRAIN
        add(0, 0, 0, 0,  0, 0, 2'b00,  0,  0, 0, 32'h0,         0, 0);
        add(0, 0, 0, 0,  0, 0, 2'b01,  0,  0, 0, 32'h0,         0, 0); // wb x0 ignored

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].srst, vecs[i].clr, vecs[i].iv, vecs[i].ir, vecs[i].ird,
                  vecs[i].ij, vecs[i].wbv, vecs[i].wb0, vecs[i].wb1, vecs[i].jd);
            e.id = i; e.locks = vecs[i].locks; e.busy = vecs[i].busy; e.err = vecs[i].err;
            sb_q.push_back(e);
            step();
            e = sb_q.pop_front();
            chk($sformatf("vec%0d locks", e.id), locks_o, e.locks);
            chk($sformatf("vec%0d busy", e.id), 32'(busy_o), 32'(e.busy));
            chk($sformatf("vec%0d err", e.id), 32'(err_o), 32'(e.err));
        end

        // Lock on x20 must hold for a random number of cycles until retired
        drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd20, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
        step();
        idle();
        k = $urandom_range(1, 4);
        for (int i = 0; i < k; i++) begin
            chk("x20 held", 32'(locks_o[20]), 32'd1);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b10, 5'd0, 5'd20, 1'b0);
        step();
        idle();
        chk("x20 released", locks_o, 32'h0);
        chk("x20 idle busy", 32'(busy_o), 32'd0);

        // Clear with x21 outstanding; after the retiring writeback the drain
        // finishes exactly one cycle later
        drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd21, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 5'd0, 5'd0, 1'b0);
        step();
        idle();
        step();
        chk("drain locks", locks_o, c_ALL);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b01, 5'd21, 5'd0, 1'b0);
        step();
        idle();
        chk("drain after wb", locks_o, c_ALL);
        waited = 0;
        while (busy_o !== 1'b0 && waited < 8) begin
            step();
            waited++;
        end
        chk("drain wait cycles", 32'(waited), 32'd1);
        chk("drain end locks", locks_o, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_rv64g_reg_lock_scoreboard
`default_nettype wire

// File: doc/rv64g_reg_lock_scoreboard.md
# rv64g_reg_lock_scoreboard

Tracks outstanding register writes and drives the per-register lock vector consumed by `rv64g_instr_launcher`. A register is set busy when an instruction writing it is launched, and released when its writeback retires. A jump in flight or a pipeline clear locks the whole register file until the datapath is quiet. It sits between the launcher's output handshake, the execution-unit writeback ports and the launcher's `locks_i` input.

## Interface
Parameters:
- `NR`, `rv64g_pkg::NUM_REGS`: number of tracked registers; index 0 is x0 and is never locked.
- `NWB`, 2: number of writeback ports.
- `CW`, 2: width of each per-register outstanding-write counter.

Ports:
- `clk_i`  in  1  clock. One clock domain.
- `srst_i`  in  1  reset; synchronous, active-high.
- `clear_i`  in  1  pipeline flush request, single-cycle pulse.
- `issue_valid_i`  in  1  launcher output valid.
- `issue_ready_i`  in  1  launcher output ready. Issue fires when valid and ready are both high.
- `issue_rd_i`  in  $clog2(NR)  destination register of the issuing instruction.
- `issue_jump_i`  in  1  issuing instruction is a jump/branch.
- `wb_valid_i`  in  NWB  per-port writeback valid.
- `wb_rd_i`  in  NWB×$clog2(NR)  per-port writeback register.
- `jump_done_i`  in  1  resolution pulse for the jump in flight.
- `locks_o`  out  NR  lock vector, connected to the launcher's `locks_i`.
- `busy_o`  out  1  any counter non-zero, or state not IDLE.
- `err_o`  out  1  one-cycle pulse on a protocol violation.

## Operation
- Per-register counter `cnt[r]`, CW bits wide.
  - On issue with rd≠0: +1.
  - For each valid writeback port with rd≠0: −1.
  - Net change is the sum of all events in the cycle. Issue and writeback to the same register in one cycle leaves the counter unchanged. Two ports writing the same register subtract 2.
- `locks_o[r] = (cnt[r]!=0) | global_lock`; `locks_o[0]` is always 0.
- `global_lock` = state is JUMP or DRAIN.
- FSM states:
  - IDLE: no counters busy and no jump pending.
  - RUN: at least one counter busy.
  - JUMP: jump issued, not yet resolved.
  - DRAIN: clear received, waiting for in-flight writebacks.
- Transitions, in priority order:
  1. `clear_i` → DRAIN from any state. A pending jump is discarded.
  2. DRAIN → IDLE when all counters are 0 and no writeback is valid.
  3. Issue with jump → JUMP.
  4. JUMP → RUN or IDLE on `jump_done_i`, chosen by the next-cycle counter state.
  5. IDLE ↔ RUN follows the OR of the counters.
- Issues are ignored in DRAIN and raise `err_o`; the launcher cannot legally issue there because every register is locked.
- Violations, each pulsing `err_o` next cycle:
  - Writeback to a register whose counter is 0: counter stays 0.
  - Issue to a saturated counter: counter holds at max.
  - `jump_done_i` outside JUMP: ignored.
  - A second jump issued while in JUMP.
- Writebacks are still counted in JUMP and DRAIN.

## Timing
- After reset: all counters 0, state IDLE, `locks_o`=0, `busy_o`=0, `err_o`=0.
- Reset takes precedence over every other input. Asserting it mid-operation returns everything to the reset values on the next edge.
- Registered outputs:
  - Issue at edge t → `locks_o[rd]` high from cycle t+1.
  - Final writeback at edge t → lock low from t+1.
- Jump issue at t → all locks high from t+1. `jump_done_i` at t → global lock drops at t+1.
- `clear_i` at t → all locks high from t+1 until the cycle after the drain completes.
- No combinational path from any input to `locks_o`.

## Structure
- `rv64g_pkg` holds the `sb_state_e` enum (IDLE, RUN, JUMP, DRAIN), `NUM_REGS` and a new `NUM_WB_PORTS` constant.
- One sub-module, `sb_counter`: a CW-bit up/multi-down counter with saturation and underflow flags, instantiated NR−1 times in a generate loop.
- The FSM and error logic live in the top module.

## Test plan
- Issue rd=5; two cycles later writeback rd=5 on port 0 → `locks_o[5]` high for exactly 2 cycles, then `busy_o`=0 and state IDLE.
- Two issues to rd=7, then writebacks on ports 0 and 1 to rd=7 in the same cycle → cnt goes 1, 2, 0 and the lock drops on the next cycle.
- Issue with jump, rd=0 → all `locks_o[NR-1:1]` high; `jump_done_i` three cycles later → locks return to the counter-only pattern one cycle later.
- Issue rd=3, then `clear_i` → all locks high; writeback rd=3 → state IDLE and locks 0 one cycle after the writeback.
- Writeback to rd=9 with cnt=0 → `err_o` pulses once and `locks_o[9]` stays 0.
- Issue rd=0 with no jump → no lock and `busy_o` stays 0. Then `srst_i` asserted mid-RUN → all outputs 0 on the next cycle.
